// File: rtl/spi_slave_if.sv
// SPI slave bus bundle: the four SPI pins plus the host-side TX/RX handshake.
// The master modport is the side that drives the SPI pins and the host strobes
// (a testbench or host wrapper). The slave modport is the spi_slave core.
interface spi_slave_if;
  logic       sck;
  logic       mosi;
  logic       ssN;
  logic       miso;
  logic       misoOe;
  logic [7:0] txData;
  logic       txWrite;
  logic       txFull;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxRead;
  logic       overrun;
  logic       busy;

  modport master (
    output sck, mosi, ssN, txData, txWrite, rxRead,
    input  miso, misoOe, txFull, rxData, rxValid, overrun, busy
  );

  modport slave (
    input  sck, mosi, ssN, txData, txWrite, rxRead,
    output miso, misoOe, txFull, rxData, rxValid, overrun, busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave, byte oriented, MSB first, with a one-entry TX buffer and a
// one-entry RX holding register.
// All SPI pins are asynchronous to clk. They are resynchronised through
// SYNC_STAGES flops, and edges are taken from the last two synchronised samples.
// Optional feature macro SPI_SLAVE_MODE_SEL_EN adds cpol/cpha inputs, which
// select any of the four SPI modes. Without the macro the core is fixed to mode 0.
module spi_slave #(
  parameter logic [7:0] IDLE_PATTERN = 8'hFF,
  parameter int         SYNC_STAGES  = 2
) (
  input logic clk,
  input logic reset,
`ifdef SPI_SLAVE_MODE_SEL_EN
  input logic cpol,
  input logic cpha,
`endif
  spi_slave_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic mode_cpol;
  logic mode_cpha;

`ifdef SPI_SLAVE_MODE_SEL_EN
  assign mode_cpol = cpol;
  assign mode_cpha = cpha;
`else
  assign mode_cpol = 1'b0;
  assign mode_cpha = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES:0]   warm;
  logic                   sck_prev;
  logic                   ss_prev;
  logic                   ss_armed;

  logic sck_now;
  logic mosi_now;
  logic ss_now;

  assign sck_now  = sck_sync[SYNC_STAGES-1];
  assign mosi_now = mosi_sync[SYNC_STAGES-1];
  assign ss_now   = ss_sync[SYNC_STAGES-1];

  // Resynchronise the pins and keep one older sample for edge detection.
  // The armed flag blocks a frame start until a real high level on ssN has been
  // seen after reset. A master that still holds ssN low must release it first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sck_sync  <= {SYNC_STAGES{mode_cpol}};
      mosi_sync <= '1;
      ss_sync   <= '1;
      sck_prev  <= mode_cpol;
      ss_prev   <= 1'b1;
      warm      <= '0;
      ss_armed  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.ssN};
      sck_prev  <= sck_now;
      ss_prev   <= ss_now;
      warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
      if (warm[SYNC_STAGES] && ss_now) begin
        ss_armed <= 1'b1;
      end
    end
  end

  logic sck_rise;
  logic sck_fall;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic shift_edge;
  logic ss_fall;
  logic ss_rise;

  assign sck_rise    = sck_now & ~sck_prev;
  assign sck_fall    = ~sck_now & sck_prev;
  assign lead_edge   = mode_cpol ? sck_fall : sck_rise;
  assign trail_edge  = mode_cpol ? sck_rise : sck_fall;
  assign sample_edge = mode_cpha ? trail_edge : lead_edge;
  assign shift_edge  = mode_cpha ? lead_edge : trail_edge;
  assign ss_fall     = ~ss_now & ss_prev & ss_armed;
  assign ss_rise     = ss_now & ~ss_prev;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] tx_shift;
  logic [7:0] tx_buf;
  logic       tx_full;
  logic [6:0] rx_shift;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun_q;
  logic       busy_q;
  logic       miso_q;
  logic       reload;
  logic       skip_first;

  // miso_q is the MSB of the outgoing shifter. tx_shift holds the bits still to be sent.
  logic [7:0] load_byte;
  logic       load_now;
  logic       byte_done;

  assign load_byte = tx_full ? tx_buf : IDLE_PATTERN;
  assign load_now  = ((state == IDLE) && ss_fall) ||
                     ((state == SHIFT) && !ss_rise && shift_edge && !skip_first && reload);
  assign byte_done = (state == SHIFT) && !ss_rise && sample_edge && (bit_cnt == 3'd7);

  // Frame FSM, shifters, TX buffer and RX holding register, all registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      tx_shift   <= IDLE_PATTERN[6:0];
      tx_buf     <= 8'h00;
      tx_full    <= 1'b0;
      rx_shift   <= 7'd0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
      miso_q     <= 1'b1;
      reload     <= 1'b0;
      skip_first <= 1'b0;
    end else begin
      if (load_now && tx_full) begin
        tx_full <= 1'b0;
      end else if (bus.txWrite && !tx_full) begin
        tx_full <= 1'b1;
        tx_buf  <= bus.txData;
      end

      if (byte_done) begin
        rx_data  <= {rx_shift, mosi_now};
        rx_valid <= 1'b1;
        if (rx_valid && !bus.rxRead) begin
          overrun_q <= 1'b1;
        end
      end else if (bus.rxRead && rx_valid) begin
        rx_valid  <= 1'b0;
        overrun_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ss_fall) begin
            state      <= SHIFT;
            busy_q     <= 1'b1;
            tx_shift   <= load_byte[6:0];
            miso_q     <= load_byte[7];
            bit_cnt    <= 3'd0;
            reload     <= 1'b0;
            skip_first <= mode_cpha;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            bit_cnt    <= 3'd0;
            reload     <= 1'b0;
            skip_first <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_shift <= {rx_shift[5:0], mosi_now};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                reload <= 1'b1;
              end
            end
            if (shift_edge) begin
              if (skip_first) begin
                skip_first <= 1'b0;
              end else if (reload) begin
                reload   <= 1'b0;
                tx_shift <= load_byte[6:0];
                miso_q   <= load_byte[7];
              end else begin
                tx_shift <= {tx_shift[5:0], 1'b1};
                miso_q   <= tx_shift[6];
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.miso    = miso_q;
  assign bus.misoOe  = busy_q;
  assign bus.busy    = busy_q;
  assign bus.txFull  = tx_full;
  assign bus.rxData  = rx_data;
  assign bus.rxValid = rx_valid;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave. A transaction-level model of the TX buffer
// and RX register predicts every observed byte and flag. The model covers the
// pending TX byte, the bytes popped at each load, and the rxValid/overrun rules.
module tb_spi_slave;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic reset;
  bit   b_cpol;
  bit   b_cpha;

  always #5 clk = ~clk;

  spi_slave_if bus();

  spi_slave #(.IDLE_PATTERN(8'hFF), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef SPI_SLAVE_MODE_SEL_EN
    .cpol  (b_cpol),
    .cpha  (b_cpha),
`endif
    .bus   (bus)
  );

  int check_count;
  int pass_count;

  bit         m_tx_pend;
  logic [7:0] m_tx_val;
  logic [7:0] m_rx_data;
  bit         m_rx_valid;
  bit         m_overrun;
  logic [7:0] m_cur;
  bit         m_first;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] model_pop();
    logic [7:0] v;
    v = m_tx_pend ? m_tx_val : 8'hFF;
    m_tx_pend = 1'b0;
    return v;
  endfunction

  task automatic model_clear();
    m_tx_pend  = 1'b0;
    m_tx_val   = 8'h00;
    m_rx_data  = 8'h00;
    m_rx_valid = 1'b0;
    m_overrun  = 1'b0;
    m_cur      = 8'hFF;
  endtask

  task automatic tx_write(input logic [7:0] d);
    bus.txData  = d;
    bus.txWrite = 1'b1;
    @(negedge clk);
    bus.txWrite = 1'b0;
    if (!m_tx_pend) begin
      m_tx_pend = 1'b1;
      m_tx_val  = d;
    end
  endtask

  task automatic rx_read();
    bus.rxRead = 1'b1;
    @(negedge clk);
    bus.rxRead = 1'b0;
    if (m_rx_valid) begin
      m_rx_valid = 1'b0;
      m_overrun  = 1'b0;
    end
  endtask

  task automatic start_frame();
    bus.sck = b_cpol;
    bus.ssN = 1'b0;
    m_cur   = model_pop();
    m_first = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic end_frame();
    wait_clk(HALF);
    bus.ssN = 1'b1;
    wait_clk(2 * HALF);
  endtask

  // Clocks nbits bits MSB first as the master. Captures miso at the master's sample point.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit wr, input logic [7:0] wd,
                      input bit rd, output logic [7:0] mi, output logic [7:0] exp_mi);
    if (b_cpha && !m_first) m_cur = model_pop();
    m_first = 1'b0;
    exp_mi  = m_cur;
    mi      = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (rd && i == 2) rx_read();
      if (wr && i == 4) tx_write(wd);
      if (!b_cpha) begin
        bus.mosi = mo[7-i];
        wait_clk(HALF);
        mi[7-i] = bus.miso;
        bus.sck = ~b_cpol;
        wait_clk(HALF);
        bus.sck = b_cpol;
      end else begin
        bus.sck  = ~b_cpol;
        bus.mosi = mo[7-i];
        wait_clk(HALF);
        mi[7-i] = bus.miso;
        bus.sck = b_cpol;
        wait_clk(HALF);
      end
    end
    if (nbits == 8) begin
      if (m_rx_valid) m_overrun = 1'b1;
      m_rx_data  = mo;
      m_rx_valid = 1'b1;
      if (!b_cpha) m_cur = model_pop();
    end
    if (!b_cpha) wait_clk(4);
  endtask

  task automatic check_model(input string tag);
    check_output({tag, "_rxData"},  bus.rxData,  m_rx_data);
    check_output({tag, "_rxValid"}, bus.rxValid, m_rx_valid);
    check_output({tag, "_overrun"}, bus.overrun, m_overrun);
    check_output({tag, "_txFull"},  bus.txFull,  m_tx_pend);
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] em;
    logic [7:0] r;
    int nb;

    check_count = 0;
    pass_count  = 0;
    b_cpol      = 1'b0;
    b_cpha      = 1'b0;
    model_clear();

    reset       = 1'b0;
    bus.ssN     = 1'b1;
    bus.sck     = 1'b0;
    bus.mosi    = 1'b1;
    bus.txData  = 8'h00;
    bus.txWrite = 1'b0;
    bus.rxRead  = 1'b0;
    wait_clk(4);
    check_output("rst_rxValid", bus.rxValid, 8'h00);
    check_output("rst_txFull",  bus.txFull,  8'h00);
    check_output("rst_busy",    bus.busy,    8'h00);
    check_output("rst_misoOe",  bus.misoOe,  8'h00);
    check_output("rst_miso",    bus.miso,    8'h01);
    check_output("rst_overrun", bus.overrun, 8'h00);
    check_output("rst_rxData",  bus.rxData,  8'h00);
    reset = 1'b1;
    wait_clk(8);

    $display("[TB] written byte A5, master sends 3C");
    tx_write(8'hA5);
    wait_clk(1);
    check_output("a5_txFull_set", bus.txFull, 8'h01);
    start_frame();
    check_output("frame_busy",   bus.busy,   8'h01);
    check_output("frame_misoOe", bus.misoOe, 8'h01);
    xfer(8'h3C, 8, 1'b0, 8'h00, 1'b0, mi, em);
    check_output("a5_miso",    mi,          8'hA5);
    check_output("a5_rxData",  bus.rxData,  8'h3C);
    check_output("a5_rxValid", bus.rxValid, 8'h01);
    check_output("a5_txFull",  bus.txFull,  8'h00);
    end_frame();
    check_output("idle_busy",   bus.busy,   8'h00);
    check_output("idle_misoOe", bus.misoOe, 8'h00);
    rx_read();
    wait_clk(1);
    check_output("read_rxValid", bus.rxValid, 8'h00);

    $display("[TB] no TX byte written, idle pattern expected");
    r = 8'($urandom);
    start_frame();
    xfer(r, 8, 1'b0, 8'h00, 1'b0, mi, em);
    check_output("idle_miso",    mi,          8'hFF);
    check_output("idle_rxValid", bus.rxValid, 8'h01);
    check_output("idle_rxData",  bus.rxData,  r);
    end_frame();
    rx_read();

    $display("[TB] back-to-back 11, 22 without read");
    start_frame();
    xfer(8'h11, 8, 1'b0, 8'h00, 1'b0, mi, em);
    xfer(8'h22, 8, 1'b0, 8'h00, 1'b0, mi, em);
    end_frame();
    check_output("b2b_rxData",  bus.rxData,  8'h22);
    check_output("b2b_overrun", bus.overrun, 8'h01);
    check_output("b2b_rxValid", bus.rxValid, 8'h01);
    rx_read();
    wait_clk(1);
    check_output("b2b_read_rxValid", bus.rxValid, 8'h00);
    check_output("b2b_read_overrun", bus.overrun, 8'h00);

    $display("[TB] partial frame then full 81");
    start_frame();
    xfer(8'hF0, 5, 1'b0, 8'h00, 1'b0, mi, em);
    end_frame();
    check_output("part_rxValid", bus.rxValid, 8'h00);
    check_output("part_overrun", bus.overrun, 8'h00);
    start_frame();
    xfer(8'h81, 8, 1'b0, 8'h00, 1'b0, mi, em);
    end_frame();
    check_output("part_next_rxData",  bus.rxData,  8'h81);
    check_output("part_next_rxValid", bus.rxValid, 8'h01);
    rx_read();

    $display("[TB] write 55 then dropped write AA");
    tx_write(8'h55);
    tx_write(8'hAA);
    wait_clk(1);
    check_output("drop_txFull", bus.txFull, 8'h01);
    start_frame();
    xfer(8'($urandom), 8, 1'b0, 8'h00, 1'b0, mi, em);
    check_output("drop_miso_55", mi, 8'h55);
    end_frame();
    start_frame();
    xfer(8'($urandom), 8, 1'b0, 8'h00, 1'b0, mi, em);
    check_output("drop_miso_ff", mi, 8'hFF);
    end_frame();
    rx_read();

    $display("[TB] randomized frames against model");
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      start_frame();
      nb = int'($urandom_range(1, 3));
      for (int b = 0; b < nb; b++) begin
        xfer(8'($urandom), 8, $urandom_range(0, 1) == 1, 8'($urandom),
             $urandom_range(0, 2) == 0, mi, em);
        check_output("rand_miso", mi, em);
        check_model("rand");
      end
      end_frame();
    end
    rx_read();

    $display("[TB] reset in mid-frame");
    tx_write(8'h3E);
    start_frame();
    xfer(8'hA7, 3, 1'b0, 8'h00, 1'b0, mi, em);
    reset = 1'b0;
    wait_clk(3);
    check_output("midrst_busy", bus.busy, 8'h00);
    reset = 1'b1;
    model_clear();
    xfer(8'hA7, 5, 1'b0, 8'h00, 1'b0, mi, em);
    check_output("midrst_stay_busy",    bus.busy,    8'h00);
    check_output("midrst_stay_rxValid", bus.rxValid, 8'h00);
    check_output("midrst_txFull",       bus.txFull,  8'h00);
    end_frame();
    start_frame();
    xfer(8'h5A, 8, 1'b0, 8'h00, 1'b0, mi, em);
    check_output("midrst_miso", mi, 8'hFF);
    end_frame();
    check_output("midrst_rxData",  bus.rxData,  8'h5A);
    check_output("midrst_rxValid", bus.rxValid, 8'h01);
    rx_read();

`ifdef SPI_SLAVE_MODE_SEL_EN
    $display("[TB] mode 3 transfer of C3");
    b_cpol  = 1'b1;
    b_cpha  = 1'b1;
    bus.sck = 1'b1;
    wait_clk(8);
    r = 8'($urandom);
    tx_write(r);
    start_frame();
    xfer(8'hC3, 8, 1'b0, 8'h00, 1'b0, mi, em);
    check_output("m3_miso", mi, r);
    end_frame();
    check_output("m3_rxData",  bus.rxData,  8'hC3);
    check_output("m3_rxValid", bus.rxValid, 8'h01);
    rx_read();
    start_frame();
    xfer(8'h96, 8, 1'b0, 8'h00, 1'b0, mi, em);
    xfer(8'h69, 8, 1'b1, 8'h4B, 1'b1, mi, em);
    check_output("m3_b2b_miso", mi, em);
    xfer(8'h0F, 8, 1'b0, 8'h00, 1'b0, mi, em);
    check_output("m3_reload_miso", mi, 8'h4B);
    end_frame();
    check_model("m3");
    b_cpol  = 1'b0;
    b_cpha  = 1'b0;
    bus.sck = 1'b0;
    wait_clk(8);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
